// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C bus monitor: event kinds, decoder states
// and the registered event record.
package i2c_mon_pkg;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_START   = 3'd1,
    EV_RESTART = 3'd2,
    EV_STOP    = 3'd3,
    EV_ADDR    = 3'd4,
    EV_DATA    = 3'd5
  } i2c_mon_ev_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  typedef struct packed {
    i2c_mon_ev_t kind;
    logic [7:0]  data;
    logic        rw;
    logic        ack;
    logic        abort;
  } i2c_mon_event_t;

  localparam logic [3:0] ACK_BIT_IDX = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer chain plus run-length glitch filter for one I2C line.
// Idle (reset) level is 1 so a released bus never produces a spurious edge.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic filt_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign filt_o   = r_filt;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], line_i};
      if (w_synced == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_filt <= w_synced;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C decoder: filtered lines -> START/RESTART/STOP detection,
// address/data byte assembly with ACK, one registered event per occurrence.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        ev_valid_o,
  output i2c_mon_ev_t ev_kind_o,
  output logic [7:0]  ev_data_o,
  output logic        ev_rw_o,
  output logic        ev_ack_o,
  output logic        ev_abort_o,
  output logic        bus_busy_o,
  output logic [7:0]  byte_cnt_o
);

  logic w_scl, w_sda;
  logic r_scl_d, r_sda_d;
  logic w_start, w_stop, w_scl_rise, w_scl_fall, w_bit;

  state_t         r_state, w_state;
  logic [7:0]     r_shift, w_shift;
  logic [3:0]     r_bit_cnt, w_bit_cnt;
  logic           r_pend, w_pend;
  logic [7:0]     r_byte_cnt, w_byte_cnt;
  logic           r_busy, w_busy;
  logic           r_ev_valid, w_ev_valid;
  i2c_mon_event_t r_ev, w_ev;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i), .filt_o(w_scl)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i), .filt_o(w_sda)
  );

  assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;
  assign w_scl_rise = ~r_scl_d & w_scl;
  assign w_scl_fall = r_scl_d & ~w_scl;
  // Same as current SDA unless SDA moved in this very cycle; then the prior level applies.
  assign w_bit      = r_sda_d;

  // Bits are taken on SCL rise but only counted on SCL fall, so the SCL rise that
  // precedes a STOP/RESTART is not mistaken for a partially shifted byte.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_pend     = r_pend;
    w_byte_cnt = r_byte_cnt;
    w_busy     = r_busy;
    w_ev_valid = 1'b0;
    w_ev       = '0;
    w_ev.rw    = r_ev.rw;
    if (w_stop) begin
      w_ev_valid = 1'b1;
      w_ev.kind  = EV_STOP;
      w_ev.abort = (r_bit_cnt != 4'd0);
      w_busy     = 1'b0;
      w_state    = S_IDLE;
      w_bit_cnt  = 4'd0;
      w_pend     = 1'b0;
    end else if (w_start) begin
      w_ev_valid = 1'b1;
      if (r_state == S_IDLE) begin
        w_ev.kind = EV_START;
      end else begin
        w_ev.kind  = EV_RESTART;
        w_ev.abort = (r_bit_cnt != 4'd0);
      end
      w_busy     = 1'b1;
      w_byte_cnt = 8'd0;
      w_bit_cnt  = 4'd0;
      w_pend     = 1'b0;
      w_shift    = 8'd0;
      w_state    = S_ADDR;
    end else if ((r_state == S_ADDR) || (r_state == S_DATA)) begin
      if (w_scl_rise) begin
        if (r_bit_cnt == ACK_BIT_IDX) begin
          w_ev_valid = 1'b1;
          w_ev.data  = r_shift;
          w_ev.ack   = w_bit;
          w_bit_cnt  = 4'd0;
          if (r_state == S_ADDR) begin
            w_ev.kind = EV_ADDR;
            w_ev.rw   = r_shift[0];
            w_state   = w_bit ? S_IGNORE : S_DATA;
          end else begin
            w_ev.kind  = EV_DATA;
            w_byte_cnt = sat_inc8(r_byte_cnt);
            if (w_bit) w_state = S_IGNORE;
          end
        end else begin
          w_shift = {r_shift[6:0], w_bit};
          w_pend  = 1'b1;
        end
      end else if (w_scl_fall && r_pend) begin
        w_bit_cnt = r_bit_cnt + 4'd1;
        w_pend    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 4'd0;
      r_pend     <= 1'b0;
      r_byte_cnt <= 8'd0;
      r_busy     <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev       <= '0;
    end else begin
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_pend     <= w_pend;
      r_byte_cnt <= w_byte_cnt;
      r_busy     <= w_busy;
      r_ev_valid <= w_ev_valid;
      r_ev       <= w_ev;
    end
  end

  assign ev_valid_o = r_ev_valid;
  assign ev_kind_o  = r_ev.kind;
  assign ev_data_o  = r_ev.data;
  assign ev_rw_o    = r_ev.rw;
  assign ev_ack_o   = r_ev.ack;
  assign ev_abort_o = r_ev.abort;
  assign bus_busy_o = r_busy;
  assign byte_cnt_o = r_byte_cnt;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: a table of bus operations with the
// event each should produce, plus glitch-timing and mid-byte reset sequences.
module tb_i2c_bus_monitor;
  import i2c_mon_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;
  localparam int T           = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda = 1'b1;
  logic        ev_valid;
  i2c_mon_ev_t ev_kind;
  logic [7:0]  ev_data;
  logic        ev_rw, ev_ack, ev_abort, busy;
  logic [7:0]  byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda),
    .ev_valid_o(ev_valid), .ev_kind_o(ev_kind), .ev_data_o(ev_data),
    .ev_rw_o(ev_rw), .ev_ack_o(ev_ack), .ev_abort_o(ev_abort),
    .bus_busy_o(busy), .byte_cnt_o(byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Captured events: {kind, data, rw, ack, abort, byte_cnt} and the cycle seen.
  logic [21:0] cap_q[$];
  int          cap_t[$];

  function automatic logic [21:0] pk(input i2c_mon_ev_t k, input logic [7:0] d, input logic r,
                                     input logic a, input logic ab, input logic [7:0] bc);
    return {k, d, r, a, ab, bc};
  endfunction

  always @(negedge clk) begin
    if (ev_valid === 1'b1) begin
      cap_q.push_back(pk(ev_kind, ev_data, ev_rw, ev_ack, ev_abort, byte_cnt));
      cap_t.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_next_ev(input string name, input logic [21:0] exp, input int exp_t);
    logic [21:0] v;
    int          t;
    if (cap_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event, expected 0x%0h", name, exp);
    end else begin
      v = cap_q.pop_front();
      t = cap_t.pop_front();
      check(name, {10'd0, v}, {10'd0, exp});
      if (exp_t >= 0) check({name, "_time"}, t, exp_t);
    end
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_t.delete();
  endtask

  task automatic wc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda = b;   wc(T);
    scl = 1'b1; wc(2 * T);
    scl = 1'b0; wc(T);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(a);
  endtask

  task automatic do_start();
    sda = 1'b0; wc(T);
    scl = 1'b0; wc(T);
  endtask

  task automatic do_restart();
    sda = 1'b1; wc(T);
    scl = 1'b1; wc(T);
    sda = 1'b0; wc(T);
    scl = 1'b0; wc(T);
  endtask

  task automatic do_stop();
    sda = 1'b0; wc(T);
    scl = 1'b1; wc(T);
    sda = 1'b1; wc(2 * T);
  endtask

  typedef enum {OP_START, OP_RESTART, OP_BYTE, OP_BITS3, OP_STOP} op_t;
  typedef struct {
    op_t         op;
    logic [7:0]  b;
    logic        ack_in;
    logic        has_ev;
    logic [21:0] exp;
    logic        busy;
  } vec_t;
  vec_t vt[$];

  task automatic add(input op_t op, input logic [7:0] b, input logic ain, input logic hev,
                     input i2c_mon_ev_t k, input logic [7:0] d, input logic r, input logic a,
                     input logic ab, input logic [7:0] bc, input logic bz);
    vec_t v;
    v.op = op; v.b = b; v.ack_in = ain; v.has_ev = hev;
    v.exp = pk(k, d, r, a, ab, bc); v.busy = bz;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    // op, byte, ack_in, has_ev, kind, data, rw, ack, abort, byte_cnt, busy
    add(OP_START,   8'h00, 0, 1, EV_START,   8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'h44, 0, 1, EV_ADDR,    8'h44, 0, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'hA5, 0, 1, EV_DATA,    8'hA5, 0, 0, 0, 8'd1, 1);
    add(OP_BYTE,    8'h3C, 0, 1, EV_DATA,    8'h3C, 0, 0, 0, 8'd2, 1);
    add(OP_STOP,    8'h00, 0, 1, EV_STOP,    8'h00, 0, 0, 0, 8'd2, 0);
    add(OP_START,   8'h00, 0, 1, EV_START,   8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'h45, 0, 1, EV_ADDR,    8'h45, 1, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'h11, 0, 1, EV_DATA,    8'h11, 1, 0, 0, 8'd1, 1);
    add(OP_BYTE,    8'h22, 1, 1, EV_DATA,    8'h22, 1, 1, 0, 8'd2, 1);
    add(OP_STOP,    8'h00, 0, 1, EV_STOP,    8'h00, 1, 0, 0, 8'd2, 0);
    add(OP_START,   8'h00, 0, 1, EV_START,   8'h00, 1, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'h44, 0, 1, EV_ADDR,    8'h44, 0, 0, 0, 8'd0, 1);
    add(OP_BITS3,   8'hA0, 0, 0, EV_NONE,    8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_RESTART, 8'h00, 0, 1, EV_RESTART, 8'h00, 0, 0, 1, 8'd0, 1);
    add(OP_BYTE,    8'h62, 0, 1, EV_ADDR,    8'h62, 0, 0, 0, 8'd0, 1);
    add(OP_STOP,    8'h00, 0, 1, EV_STOP,    8'h00, 0, 0, 0, 8'd0, 0);
    add(OP_START,   8'h00, 0, 1, EV_START,   8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'hA0, 1, 1, EV_ADDR,    8'hA0, 0, 1, 0, 8'd0, 1);
    add(OP_BYTE,    8'hFF, 0, 0, EV_NONE,    8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_BYTE,    8'h00, 1, 0, EV_NONE,    8'h00, 0, 0, 0, 8'd0, 1);
    add(OP_STOP,    8'h00, 0, 1, EV_STOP,    8'h00, 0, 0, 0, 8'd0, 0);

    rst = 1'b0;
    wc(3);
    check("reset_outputs", {ev_valid, ev_kind, ev_data, ev_rw, ev_ack, ev_abort, busy, byte_cnt}, 32'd0);
    rst = 1'b1;
    wc(20);

    foreach (vt[i]) begin
      clear_cap();
      case (vt[i].op)
        OP_START:   do_start();
        OP_RESTART: do_restart();
        OP_BYTE:    send_byte(vt[i].b, vt[i].ack_in);
        OP_BITS3:   for (int j = 7; j >= 5; j--) send_bit(vt[i].b[j]);
        default:    do_stop();
      endcase
      check($sformatf("vec%0d_count", i), cap_q.size(), vt[i].has_ev ? 32'd1 : 32'd0);
      if (vt[i].has_ev && cap_q.size() > 0) check_next_ev($sformatf("vec%0d_event", i), vt[i].exp, -1);
      check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
    end

    // Short SDA glitch with SCL high must vanish in the filter.
    clear_cap();
    wc(1);
    sda = 1'b0; wc(3);
    sda = 1'b1; wc(30);
    check("glitch3_none", cap_q.size(), 0);

    // A 6-cycle pulse survives: START then STOP, each LAT cycles after its pin edge.
    begin
      int t0, t1;
      clear_cap();
      wc(1);
      sda = 1'b0; t0 = cyc; wc(6);
      sda = 1'b1; t1 = cyc; wc(30);
      check("glitch6_count", cap_q.size(), 2);
      check_next_ev("glitch6_start", pk(EV_START, 8'h00, 0, 0, 0, 8'd0), t0 + LAT);
      check_next_ev("glitch6_stop",  pk(EV_STOP,  8'h00, 0, 0, 0, 8'd0), t1 + LAT);
    end

    // Reset in the middle of a read data byte, then a clean transaction.
    do_start();
    send_byte(8'h45, 1'b0);
    send_byte(8'h11, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    sda = 1'b1; wc(T);
    scl = 1'b1; wc(T);
    check("pre_reset_busy", busy, 1);
    clear_cap();
    rst = 1'b0;
    wc(2);
    check("midreset_outputs", {ev_valid, ev_kind, ev_data, ev_rw, ev_ack, ev_abort, busy, byte_cnt}, 32'd0);
    rst = 1'b1;
    wc(T);
    scl = 1'b0; wc(T);
    scl = 1'b1; wc(2 * T);
    check("postreset_no_stop", cap_q.size(), 0);
    do_start();
    send_byte(8'h62, 1'b0);
    do_stop();
    check("postreset_count", cap_q.size(), 3);
    check_next_ev("postreset_start", pk(EV_START, 8'h00, 0, 0, 0, 8'd0), -1);
    check_next_ev("postreset_addr",  pk(EV_ADDR,  8'h62, 0, 0, 0, 8'd0), -1);
    check_next_ev("postreset_stop",  pk(EV_STOP,  8'h00, 0, 0, 0, 8'd0), -1);
    check("postreset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
